// File: rtl/sap_control_sequencer_if.sv
// ----------------------------------------------------------------------------
// sap_control_sequencer_if
//
// Purpose:
//   Bundles the control sequencer's datapath-facing signals: the opcode and
//   ALU status coming in, and the one-hot control lines, debug step and flag
//   outputs going back out to the SAP-style 8-bit datapath.
//
// Signals:
//   ir_op[3:0]   opcode field IR[7:4], valid from T2 onward
//   alu_carry    ALU carry-out
//   alu_zero     ALU result == 0
//   pc_clr       program counter clear (registered)
//   pc_inc       program counter increment
//   pc_jmp       program counter load from bus
//   pc_oe        program counter drive bus
//   mar_in       MAR load from bus
//   ram_in       RAM write from bus
//   ram_oe       RAM drive bus
//   ir_in        IR load
//   ir_oe        IR operand (low nibble) drive bus
//   a_in / a_oe  A register load / drive bus
//   b_in         B register load
//   alu_oe       ALU drive bus
//   alu_sub      ALU subtract
//   out_in       output register load
//   hlt          clock halt request
//   step[2:0]    current T-state (debug)
//   c_flag       registered carry flag
//   z_flag       registered zero flag
//
// Modports:
//   master  the sequencer (drives control lines, reads opcode/ALU status)
//   slave   the datapath side (the reverse)
// ----------------------------------------------------------------------------
interface sap_control_sequencer_if;
    logic [3:0] ir_op;
    logic       alu_carry;
    logic       alu_zero;

    logic       pc_clr;
    logic       pc_inc;
    logic       pc_jmp;
    logic       pc_oe;
    logic       mar_in;
    logic       ram_in;
    logic       ram_oe;
    logic       ir_in;
    logic       ir_oe;
    logic       a_in;
    logic       a_oe;
    logic       b_in;
    logic       alu_oe;
    logic       alu_sub;
    logic       out_in;
    logic       hlt;
    logic [2:0] step;
    logic       c_flag;
    logic       z_flag;

    modport master (
        input  ir_op, alu_carry, alu_zero,
        output pc_clr, pc_inc, pc_jmp, pc_oe, mar_in, ram_in, ram_oe,
               ir_in, ir_oe, a_in, a_oe, b_in, alu_oe, alu_sub, out_in,
               hlt, step, c_flag, z_flag
    );

    modport slave (
        output ir_op, alu_carry, alu_zero,
        input  pc_clr, pc_inc, pc_jmp, pc_oe, mar_in, ram_in, ram_oe,
               ir_in, ir_oe, a_in, a_oe, b_in, alu_oe, alu_sub, out_in,
               hlt, step, c_flag, z_flag
    );
endinterface

// File: rtl/sap_control_sequencer.sv
// ----------------------------------------------------------------------------
// sap_control_sequencer
//
// Purpose:
//   Microcoded control sequencer for the 8-bit SAP-style datapath. Steps each
//   instruction through fetch (T0, T1) and execute (T2..T4) T-states, decoding
//   the one-hot control lines from the current step, opcode and registered
//   carry/zero flags. Holds the flag register, the halt latch and the
//   registered program-counter clear; it is the only driver of the program
//   counter's control pins.
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   clr_n  asynchronous active-low reset
//   bus    sap_control_sequencer_if.master (opcode/ALU status in,
//          control lines, step and flags out)
//
// Configuration:
//   SEQ_EARLY_END_EN  when defined, an instruction returns to T0 right after
//                     its last step carrying microcode instead of always
//                     running through T4.
// ----------------------------------------------------------------------------
module sap_control_sequencer (
    input  logic                          clk,
    input  logic                          clr_n,
    sap_control_sequencer_if.master       bus
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    step_t step_q, step_d;
    logic  c_q, z_q;
    logic  halted_q;
    logic  pc_clr_q;

    logic  run;        // decode enabled: out of reset, clear cycle done, not halted
    logic  flags_in;   // ADD/SUB T4 captures ALU status into C/Z
    logic  halt_now;   // HLT at T2: set the halt latch at this edge
    logic  last_step;  // current step ends the instruction

    // Reset, the post-reset clear cycle and the halt latch all silence the
    // decode; clr_n is used directly so lines drop the instant reset asserts.
    assign run = clr_n & ~pc_clr_q & ~halted_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            step_q   <= T0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            halted_q <= 1'b0;
            pc_clr_q <= 1'b1;
        end else begin
            step_q   <= step_d;
            pc_clr_q <= 1'b0;
            if (halt_now) begin
                halted_q <= 1'b1;
            end
            if (flags_in) begin
                c_q <= bus.alu_carry;
                z_q <= bus.alu_zero;
            end
        end
    end

    // ------------------------------------------------------------------
    // Last-step table
    // ------------------------------------------------------------------
    always_comb begin
`ifdef SEQ_EARLY_END_EN
        unique case (bus.ir_op)
            OP_LDA, OP_STA:                         last_step = (step_q == T3);
            OP_ADD, OP_SUB:                         last_step = (step_q == T4);
            OP_LDI, OP_JMP, OP_JC, OP_JZ,
            OP_OUT, OP_HLT:                         last_step = (step_q == T2);
            default:                                last_step = (step_q == T1);
        endcase
`else
        last_step = (step_q == T4);
`endif
    end

    // ------------------------------------------------------------------
    // Next step and control decode
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case
    // statements, so no path leaves a signal unassigned and no latch is
    // inferred.
    always_comb begin
        step_d      = step_q;
        flags_in    = 1'b0;
        halt_now    = 1'b0;

        bus.pc_inc  = 1'b0;
        bus.pc_jmp  = 1'b0;
        bus.pc_oe   = 1'b0;
        bus.mar_in  = 1'b0;
        bus.ram_in  = 1'b0;
        bus.ram_oe  = 1'b0;
        bus.ir_in   = 1'b0;
        bus.ir_oe   = 1'b0;
        bus.a_in    = 1'b0;
        bus.a_oe    = 1'b0;
        bus.b_in    = 1'b0;
        bus.alu_oe  = 1'b0;
        bus.alu_sub = 1'b0;
        bus.out_in  = 1'b0;

        if (run) begin
            unique case (step_q)
                T0: begin
                    bus.pc_oe  = 1'b1;
                    bus.mar_in = 1'b1;
                end
                T1: begin
                    bus.ram_oe = 1'b1;
                    bus.ir_in  = 1'b1;
                    bus.pc_inc = 1'b1;
                end
                T2: begin
                    unique case (bus.ir_op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            bus.ir_oe  = 1'b1;
                            bus.mar_in = 1'b1;
                        end
                        OP_LDI: begin
                            bus.ir_oe = 1'b1;
                            bus.a_in  = 1'b1;
                        end
                        OP_JMP: begin
                            bus.ir_oe  = 1'b1;
                            bus.pc_jmp = 1'b1;
                        end
                        // Conditional jumps look at the registered flags, so a
                        // preceding ADD/SUB's result is already visible here.
                        OP_JC: begin
                            bus.ir_oe  = c_q;
                            bus.pc_jmp = c_q;
                        end
                        OP_JZ: begin
                            bus.ir_oe  = z_q;
                            bus.pc_jmp = z_q;
                        end
                        OP_OUT: begin
                            bus.a_oe   = 1'b1;
                            bus.out_in = 1'b1;
                        end
                        OP_HLT: begin
                            halt_now = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    unique case (bus.ir_op)
                        OP_LDA: begin
                            bus.ram_oe = 1'b1;
                            bus.a_in   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            bus.ram_oe = 1'b1;
                            bus.b_in   = 1'b1;
                        end
                        OP_STA: begin
                            bus.a_oe   = 1'b1;
                            bus.ram_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (bus.ir_op == OP_ADD || bus.ir_op == OP_SUB) begin
                        bus.alu_oe  = 1'b1;
                        bus.a_in    = 1'b1;
                        bus.alu_sub = (bus.ir_op == OP_SUB);
                        flags_in    = 1'b1;
                    end
                end
                default: ;
            endcase

            // Step freezes at the HLT edge; the halt latch keeps it there.
            if (!halt_now) begin
                step_d = last_step ? T0 : step_t'(step_q + 3'd1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered / status outputs
    // ------------------------------------------------------------------
    assign bus.pc_clr = pc_clr_q;
    assign bus.hlt    = halted_q | halt_now;
    assign bus.step   = step_q;
    assign bus.c_flag = c_q;
    assign bus.z_flag = z_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_sap_control_sequencer
//
// Directed bench for sap_control_sequencer. Control lines are packed into a
// 16-bit word and compared against hand-built expected words each cycle,
// sampled on the falling clock edge. Works with or without SEQ_EARLY_END_EN.
// ----------------------------------------------------------------------------
module tb_sap_control_sequencer;

    localparam logic [15:0] PC_CLR  = 16'h8000;
    localparam logic [15:0] PC_INC  = 16'h4000;
    localparam logic [15:0] PC_JMP  = 16'h2000;
    localparam logic [15:0] PC_OE   = 16'h1000;
    localparam logic [15:0] MAR_IN  = 16'h0800;
    localparam logic [15:0] RAM_IN  = 16'h0400;
    localparam logic [15:0] RAM_OE  = 16'h0200;
    localparam logic [15:0] IR_IN   = 16'h0100;
    localparam logic [15:0] IR_OE   = 16'h0080;
    localparam logic [15:0] A_IN    = 16'h0040;
    localparam logic [15:0] A_OE    = 16'h0020;
    localparam logic [15:0] B_IN    = 16'h0010;
    localparam logic [15:0] ALU_OE  = 16'h0008;
    localparam logic [15:0] ALU_SUB = 16'h0004;
    localparam logic [15:0] OUT_IN  = 16'h0002;
    localparam logic [15:0] HLT     = 16'h0001;
    localparam logic [15:0] NONE    = 16'h0000;

    logic clk;
    logic clr_n;
    int   n_checks;
    int   n_fail;

    sap_control_sequencer_if bus ();

    sap_control_sequencer dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ctrl_word();
        return {bus.pc_clr, bus.pc_inc, bus.pc_jmp, bus.pc_oe, bus.mar_in,
                bus.ram_in, bus.ram_oe, bus.ir_in, bus.ir_oe, bus.a_in,
                bus.a_oe, bus.b_in, bus.alu_oe, bus.alu_sub, bus.out_in,
                bus.hlt};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Check step and control word in the current cycle, then move to the
    // next falling edge.
    task automatic cyc(input string tag, input logic [2:0] exp_step, input logic [15:0] exp_ctrl);
        #1;
        check({tag, "_step"}, {13'd0, bus.step}, {13'd0, exp_step});
        check({tag, "_ctrl"}, ctrl_word(), exp_ctrl);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch(input string tag);
        cyc({tag, "_t0"}, 3'd0, PC_OE | MAR_IN);
        cyc({tag, "_t1"}, 3'd1, RAM_OE | IR_IN | PC_INC);
    endtask

    // Empty trailing steps exist only in the full five-step build.
    task automatic pad(input string tag, input int last);
`ifndef SEQ_EARLY_END_EN
        for (int s = last + 1; s <= 4; s++) begin
            cyc({tag, "_pad"}, 3'(s), NONE);
        end
`endif
    endtask

    task automatic check_flags(input string tag, input logic exp_c, input logic exp_z);
        #1;
        check({tag, "_c"}, {15'd0, bus.c_flag}, {15'd0, exp_c});
        check({tag, "_z"}, {15'd0, bus.z_flag}, {15'd0, exp_z});
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        clr_n         = 1'b0;
        bus.ir_op     = 4'h0;
        bus.alu_carry = 1'b0;
        bus.alu_zero  = 1'b0;

        // ---------------- reset and clear ----------------
        repeat (2) @(negedge clk);
        check_flags("reset", 1'b0, 1'b0);
        #1;
        check("reset_ctrl", ctrl_word(), PC_CLR);
        check("reset_step", {13'd0, bus.step}, 16'd0);
        clr_n = 1'b1;
        cyc("clear_cycle", 3'd0, PC_CLR);

        // ---------------- LDA ----------------
        bus.ir_op = 4'h1;
        fetch("lda");
        cyc("lda_t2", 3'd2, IR_OE | MAR_IN);
        cyc("lda_t3", 3'd3, RAM_OE | A_IN);
        pad("lda", 3);

        // ---------------- NOP (opcode 0) ----------------
        bus.ir_op = 4'h0;
        fetch("nop");
        pad("nop", 1);

        // ---------------- ADD sets flags ----------------
        bus.ir_op     = 4'h2;
        bus.alu_carry = 1'b1;
        bus.alu_zero  = 1'b1;
        fetch("add");
        cyc("add_t2", 3'd2, IR_OE | MAR_IN);
        cyc("add_t3", 3'd3, RAM_OE | B_IN);
        check_flags("add_pre", 1'b0, 1'b0);
        cyc("add_t4", 3'd4, ALU_OE | A_IN);
        check_flags("add_post", 1'b1, 1'b1);
        bus.alu_carry = 1'b0;
        bus.alu_zero  = 1'b0;

        // ---------------- JC / JZ taken ----------------
        bus.ir_op = 4'h7;
        fetch("jc_taken");
        cyc("jc_taken_t2", 3'd2, IR_OE | PC_JMP);
        pad("jc_taken", 2);
        bus.ir_op = 4'h8;
        fetch("jz_taken");
        cyc("jz_taken_t2", 3'd2, IR_OE | PC_JMP);
        pad("jz_taken", 2);

        // ---------------- SUB clears flags ----------------
        bus.ir_op = 4'h3;
        fetch("sub");
        cyc("sub_t2", 3'd2, IR_OE | MAR_IN);
        cyc("sub_t3", 3'd3, RAM_OE | B_IN);
        check_flags("sub_pre", 1'b1, 1'b1);
        cyc("sub_t4", 3'd4, ALU_OE | A_IN | ALU_SUB);
        check_flags("sub_post", 1'b0, 1'b0);

        // ---------------- JC / JZ not taken ----------------
        bus.ir_op = 4'h7;
        fetch("jc_nt");
        cyc("jc_nt_t2", 3'd2, NONE);
        pad("jc_nt", 2);
        bus.ir_op = 4'h8;
        fetch("jz_nt");
        cyc("jz_nt_t2", 3'd2, NONE);
        pad("jz_nt", 2);

        // ---------------- STA / LDI / JMP / OUT ----------------
        bus.ir_op = 4'h4;
        fetch("sta");
        cyc("sta_t2", 3'd2, IR_OE | MAR_IN);
        cyc("sta_t3", 3'd3, A_OE | RAM_IN);
        pad("sta", 3);
        bus.ir_op = 4'h5;
        fetch("ldi");
        cyc("ldi_t2", 3'd2, IR_OE | A_IN);
        pad("ldi", 2);
        bus.ir_op = 4'h6;
        fetch("jmp");
        cyc("jmp_t2", 3'd2, IR_OE | PC_JMP);
        pad("jmp", 2);
        bus.ir_op = 4'hE;
        fetch("out");
        cyc("out_t2", 3'd2, A_OE | OUT_IN);
        pad("out", 2);

        // ---------------- reset mid-ADD ----------------
        bus.ir_op     = 4'h2;
        bus.alu_carry = 1'b1;
        bus.alu_zero  = 1'b1;
        fetch("add2");
        cyc("add2_t2", 3'd2, IR_OE | MAR_IN);
        cyc("add2_t3", 3'd3, RAM_OE | B_IN);
        cyc("add2_t4", 3'd4, ALU_OE | A_IN);
        check_flags("add2_post", 1'b1, 1'b1);
        fetch("add3");
        cyc("add3_t2", 3'd2, IR_OE | MAR_IN);
        #1;
        check("add3_t3_pre", ctrl_word(), RAM_OE | B_IN);
        clr_n = 1'b0;
        #1;
        check("midreset_ctrl", ctrl_word(), PC_CLR);
        check("midreset_step", {13'd0, bus.step}, 16'd0);
        check_flags("midreset", 1'b0, 1'b0);
        @(negedge clk);
        clr_n = 1'b1;
        bus.alu_carry = 1'b0;
        bus.alu_zero  = 1'b0;
        cyc("midreset_clear", 3'd0, PC_CLR);
        cyc("midreset_t0", 3'd0, PC_OE | MAR_IN);

        // Finish that instruction (op is ADD, now at T1) to realign.
        cyc("realign_t1", 3'd1, RAM_OE | IR_IN | PC_INC);
        cyc("realign_t2", 3'd2, IR_OE | MAR_IN);
        cyc("realign_t3", 3'd3, RAM_OE | B_IN);
        cyc("realign_t4", 3'd4, ALU_OE | A_IN);

        // ---------------- HLT ----------------
        bus.ir_op = 4'hF;
        fetch("hlt");
        cyc("hlt_t2", 3'd2, HLT);
        bus.ir_op     = 4'h1;
        bus.alu_carry = 1'b1;
        for (int i = 0; i < 22; i++) begin
            cyc("hlt_hold", 3'd2, HLT);
        end
        check_flags("hlt_hold", 1'b0, 1'b0);
        clr_n = 1'b0;
        #1;
        check("hlt_reset_ctrl", ctrl_word(), PC_CLR);
        check("hlt_reset_step", {13'd0, bus.step}, 16'd0);
        @(negedge clk);
        clr_n = 1'b1;
        cyc("hlt_clear", 3'd0, PC_CLR);
        cyc("hlt_restart_t0", 3'd0, PC_OE | MAR_IN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sap_control_sequencer.md
# sap_control_sequencer

- Microcoded control sequencer for the 8-bit SAP-style datapath.
- Steps each instruction through fetch and execute T-states. On each step it drives the one-hot-per-function control lines for the program counter (clr/inc/jmp/oe), MAR, RAM, instruction register, A/B registers, ALU and output register.
- Sits directly upstream of the program counter: it is the sole driver of that counter's control pins.
- Holds the carry/zero flag register and the halt latch.

## Interface
Parameters:
- none (microcode fixed; 5 T-states T0..T4)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- clr_n  in  1  asynchronous active-low reset
- ir_op  in  4  opcode field (IR[7:4]); valid from T2 onward
- alu_carry  in  1  ALU carry-out
- alu_zero  in  1  ALU result == 0
- pc_clr  out  1  program counter clear (registered)
- pc_inc  out  1  program counter increment
- pc_jmp  out  1  program counter load from bus
- pc_oe  out  1  program counter drive bus
- mar_in  out  1  MAR load from bus
- ram_in  out  1  RAM write from bus
- ram_oe  out  1  RAM drive bus
- ir_in  out  1  IR load
- ir_oe  out  1  IR operand (low nibble) drive bus
- a_in  out  1  A register load
- a_oe  out  1  A register drive bus
- b_in  out  1  B register load
- alu_oe  out  1  ALU drive bus
- alu_sub  out  1  ALU subtract
- out_in  out  1  output register load
- hlt  out  1  clock halt request
- step  out  3  current T-state (debug)
- c_flag  out  1  registered carry flag
- z_flag  out  1  registered zero flag

## Operation
- State:
  - step register 0..4
  - flags C, Z
  - halted latch
  - pc_clr register
- Control outputs other than pc_clr/hlt/flags are a combinational decode of step, ir_op, C, Z. Unlisted lines are 0.
- Fetch, all opcodes:
  - T0: pc_oe, mar_in
  - T1: ram_oe, ir_in, pc_inc
- Execute, by opcode:
  - 0x1 LDA: T2 ir_oe,mar_in; T3 ram_oe,a_in
  - 0x2 ADD: T2 ir_oe,mar_in; T3 ram_oe,b_in; T4 alu_oe,a_in,flags_in
  - 0x3 SUB: as ADD, plus alu_sub at T4
  - 0x4 STA: T2 ir_oe,mar_in; T3 a_oe,ram_in
  - 0x5 LDI: T2 ir_oe,a_in
  - 0x6 JMP: T2 ir_oe,pc_jmp
  - 0x7 JC: T2 ir_oe,pc_jmp only if C=1; otherwise no lines asserted
  - 0x8 JZ: T2 ir_oe,pc_jmp only if Z=1; otherwise no lines asserted
  - 0xE OUT: T2 a_oe,out_in
  - 0xF HLT: T2 hlt; halted latch sets at that edge
  - all other opcodes: NOP, no execute lines
- Flags:
  - flags_in is internal.
  - When flags_in=1, C<=alu_carry and Z<=alu_zero at the edge.
  - Otherwise flags hold.
- Halted:
  - step frozen.
  - hlt=1 and every other control line 0 until reset.

## Timing
- Reset (clr_n=0), effective immediately:
  - step=0, C=Z=0, halted=0, pc_clr=1
  - all combinational control lines forced 0
- First rising edge after clr_n deasserts:
  - pc_clr=1 is still presented to the counter during this cycle, so it clears synchronously.
  - pc_clr then falls to 0.
  - step stays 0.
  - Fetch begins the following cycle.
- Step advance: step increments each edge; after T4 it wraps to T0.
- One instruction = 5 cycles (baseline; see Configuration).
- Reset mid-instruction aborts it immediately; there is no partial completion.
- JC/JZ sample the registered flags, so an ADD/SUB immediately before a jump is visible to it.

## Configuration
- SEQ_EARLY_END_EN defined:
  - After the last step with asserted microcode for the opcode, the next step is T0.
  - Last steps: NOP T1; LDI/JMP/JC/JZ/OUT T2; LDA/STA T3; ADD/SUB T4.
  - A not-taken JC/JZ still ends after T2.
- Undefined: every instruction takes the full T0..T4. Empty steps assert nothing.

## Test plan
- Reset and clear:
  - Stimulus: hold clr_n=0, then release.
  - Required: pc_clr=1 during reset and for exactly one cycle after release; step=0 for that cycle; T0 decode (pc_oe=mar_in=1) next cycle.
- LDA fetch/execute:
  - Stimulus: ir_op=0x1.
  - Required sequence: T0 pc_oe+mar_in; T1 ram_oe+ir_in+pc_inc; T2 ir_oe+mar_in; T3 ram_oe+a_in.
  - Next instruction at T0: after T3 with SEQ_EARLY_END_EN; after T4 without.
- ADD sets flags:
  - Stimulus: ir_op=0x2 with alu_carry=1, alu_zero=1 at T4.
  - Required: T4 asserts alu_oe+a_in; c_flag=z_flag=1 after that edge.
  - Follow-up: SUB with alu_carry=0, alu_zero=0 clears both flags and asserts alu_sub at T4 only.
- JC conditional:
  - With C=1, ir_op=0x7: T2 asserts ir_oe+pc_jmp.
  - With C=0: T2 asserts nothing.
  - JZ checked likewise against z_flag.
- HLT:
  - Stimulus: ir_op=0xF.
  - Required: hlt=1 from T2 onward; step frozen at 2; all other lines 0 for 20+ cycles; clr_n pulse returns hlt=0, step=0.
- Reset mid-ADD:
  - Stimulus: assert clr_n=0 at T3.
  - Required: outputs drop to 0 and step=0 immediately; C/Z cleared; pc_clr=1.
